// File: rtl/brs_sum_fifo.sv
//==============================================================================
// brs_sum_fifo : adds operand pairs with carry-out and buffers sums in a FIFO
// Revision: 1.0
//==============================================================================
`default_nettype none

module brs_sum_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ena,
  input  logic                  clear,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_a,
  input  logic [WIDTH-1:0]      in_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_data,
  output logic                  out_carry,
  output logic [DEPTH_LOG2:0]   count,
  output logic [7:0]            drop_cnt,
  output logic                  carry_seen
);

  localparam int                  DEPTH      = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_COUNT = DEPTH[DEPTH_LOG2:0];
  localparam logic [7:0]          DROP_MAX   = 8'hFF;

  logic [WIDTH:0]        mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [DEPTH_LOG2-1:0] rd_ptr;
  logic [WIDTH:0]        sum;
  logic [WIDTH:0]        head;
  logic                  push;
  logic                  pop;
  logic                  drop;

  assign sum = {1'b0, in_a} + {1'b0, in_b};

  // Handshake flags come only from registered occupancy, never from out_ready.
  assign in_ready  = (count != FULL_COUNT);
  assign out_valid = (count != '0);

  // A clear cycle swallows the offered pair without counting it as a drop.
  assign push = ena & ~clear & in_valid & in_ready;
  assign pop  = ena & ~clear & out_valid & out_ready;
  assign drop = ena & ~clear & in_valid & ~in_ready;

  assign head      = out_valid ? mem[rd_ptr] : '0;
  assign out_data  = head[WIDTH-1:0];
  assign out_carry = head[WIDTH];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      drop_cnt   <= '0;
      carry_seen <= 1'b0;
    end else if (ena) begin
      if (clear) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
        drop_cnt   <= '0;
        carry_seen <= 1'b0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
        if (drop && (drop_cnt != DROP_MAX)) begin
          drop_cnt <= drop_cnt + 1'b1;
        end
        if (push && sum[WIDTH]) begin
          carry_seen <= 1'b1;
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_brs_sum_fifo.sv
//==============================================================================
// tb_brs_sum_fifo : directed table, corner sequences and random vs queue model
// Revision: 1.0
//==============================================================================
`default_nettype none

module tb_brs_sum_fifo;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_carry;
  logic [2:0] count;
  logic [7:0] drop_cnt;
  logic       carry_seen;

  int checks = 0;
  int errors = 0;

  brs_sum_fifo #(.WIDTH(8), .DEPTH_LOG2(2)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_carry(out_carry), .count(count), .drop_cnt(drop_cnt),
    .carry_seen(carry_seen)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       ena, clr, iv, ordy;
    logic [7:0] a, b;
    logic [2:0] e_count;
    logic       e_valid, e_ready;
    logic [7:0] e_data;
    logic       e_carry;
    logic [7:0] e_drop;
    logic       e_cs;
  } vec_t;

  function automatic vec_t mkv(int en, int cl, int iv, int ordy, int a, int b,
                               int cnt, int vl, int rdy, int d, int c, int dr, int cs);
    vec_t v;
    v.ena = en[0];  v.clr = cl[0];  v.iv = iv[0];  v.ordy = ordy[0];
    v.a = a[7:0];  v.b = b[7:0];  v.e_count = cnt[2:0];
    v.e_valid = vl[0];  v.e_ready = rdy[0];  v.e_data = d[7:0];
    v.e_carry = c[0];  v.e_drop = dr[7:0];  v.e_cs = cs[0];
    return v;
  endfunction

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(logic en, logic cl, logic iv, logic ordy, logic [7:0] a, logic [7:0] b);
    ena = en;  clear = cl;  in_valid = iv;  out_ready = ordy;  in_a = a;  in_b = b;
  endtask

  task automatic chk_state(string tag, int cnt, int vl, int rdy, int d, int c, int dr, int cs);
    chk({tag, ".count"},      int'(count),      cnt);
    chk({tag, ".out_valid"},  int'(out_valid),  vl);
    chk({tag, ".in_ready"},   int'(in_ready),   rdy);
    chk({tag, ".out_data"},   int'(out_data),   d);
    chk({tag, ".out_carry"},  int'(out_carry),  c);
    chk({tag, ".drop_cnt"},   int'(drop_cnt),   dr);
    chk({tag, ".carry_seen"}, int'(carry_seen), cs);
  endtask

  vec_t vecs [24];
  logic [8:0] q [$];
  int mdrop;
  int mcs;

  initial begin
    //          en cl iv rd   a     b     cnt vl rdy data  c drop cs
    vecs[0]  = mkv(1,0,1,0, 'h12, 'h34,   1, 1, 1, 'h46, 0, 0, 0);
    vecs[1]  = mkv(1,0,1,0, 'hFF, 'h02,   2, 1, 1, 'h46, 0, 0, 1);
    vecs[2]  = mkv(1,0,0,1, 0,    0,      1, 1, 1, 'h01, 1, 0, 1);
    vecs[3]  = mkv(1,0,0,1, 0,    0,      0, 0, 1, 0,    0, 0, 1);
    vecs[4]  = mkv(1,1,0,0, 0,    0,      0, 0, 1, 0,    0, 0, 0);
    vecs[5]  = mkv(1,0,1,0, 1,    1,      1, 1, 1, 'h02, 0, 0, 0);
    vecs[6]  = mkv(1,0,1,0, 2,    2,      2, 1, 1, 'h02, 0, 0, 0);
    vecs[7]  = mkv(1,0,1,0, 3,    3,      3, 1, 1, 'h02, 0, 0, 0);
    vecs[8]  = mkv(1,0,1,0, 4,    4,      4, 1, 0, 'h02, 0, 0, 0);
    vecs[9]  = mkv(1,0,1,0, 5,    5,      4, 1, 0, 'h02, 0, 1, 0);
    vecs[10] = mkv(1,0,1,0, 5,    5,      4, 1, 0, 'h02, 0, 2, 0);
    vecs[11] = mkv(1,0,1,0, 5,    5,      4, 1, 0, 'h02, 0, 3, 0);
    vecs[12] = mkv(1,0,1,1, 9,    9,      3, 1, 1, 'h04, 0, 4, 0);
    vecs[13] = mkv(1,0,1,0, 9,    9,      4, 1, 0, 'h04, 0, 4, 0);
    vecs[14] = mkv(1,0,0,1, 0,    0,      3, 1, 1, 'h06, 0, 4, 0);
    vecs[15] = mkv(1,0,0,1, 0,    0,      2, 1, 1, 'h08, 0, 4, 0);
    vecs[16] = mkv(1,0,0,1, 0,    0,      1, 1, 1, 'h12, 0, 4, 0);
    vecs[17] = mkv(1,0,0,1, 0,    0,      0, 0, 1, 0,    0, 4, 0);
    vecs[18] = mkv(0,0,1,0, 1,    1,      0, 0, 1, 0,    0, 4, 0);
    vecs[19] = mkv(0,1,1,0, 1,    1,      0, 0, 1, 0,    0, 4, 0);
    vecs[20] = mkv(1,0,1,0, 'h10, 'h20,   1, 1, 1, 'h30, 0, 4, 0);
    vecs[21] = mkv(1,0,1,0, 'h80, 'h80,   2, 1, 1, 'h30, 0, 4, 1);
    vecs[22] = mkv(0,0,1,1, 7,    7,      2, 1, 1, 'h30, 0, 4, 1);
    vecs[23] = mkv(1,1,1,1, 5,    5,      0, 0, 1, 0,    0, 0, 0);

    rst_n = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    chk_state("reset", 0, 0, 1, 0, 0, 0, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      drive(vecs[i].ena, vecs[i].clr, vecs[i].iv, vecs[i].ordy, vecs[i].a, vecs[i].b);
      tick();
      chk_state($sformatf("vec%0d", i), vecs[i].e_count, vecs[i].e_valid, vecs[i].e_ready,
                vecs[i].e_data, vecs[i].e_carry, vecs[i].e_drop, vecs[i].e_cs);
    end

    // Streaming: one entry in flight, head tracks 3*i.
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b1, 8'(i), 8'(2 * i));
      tick();
      chk($sformatf("stream%0d.out_data", i), int'(out_data), (3 * i) & 255);
      chk($sformatf("stream%0d.count", i), int'(count), 1);
    end
    chk("stream.drop_cnt", int'(drop_cnt), 0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    tick();
    chk("stream.drained", int'(count), 0);

    // Drop counter saturation.
    for (int i = 0; i < 264; i++) begin
      drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h01, 8'h01);
      tick();
    end
    chk("sat.drop_cnt", int'(drop_cnt), 255);
    tick();
    chk("sat.hold", int'(drop_cnt), 255);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick();
    chk_state("sat.clear", 0, 0, 1, 0, 0, 0, 0);

    // Asynchronous reset between edges.
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h21, 8'h22);
    tick();
    tick();
    chk("arst.pre_count", int'(count), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.out_valid", int'(out_valid), 0);
    chk("arst.count", int'(count), 0);
    chk("arst.in_ready", int'(in_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 8'h21, 8'h22);
    tick();
    chk_state("arst.after", 1, 1, 1, 'h43, 0, 0, 0);

    // Random traffic against a queue model.
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    q.delete();
    mdrop = 0;
    mcs = 0;
    for (int n = 0; n < 600; n++) begin
      logic       r_en, r_cl, r_iv, r_or;
      logic [7:0] r_a, r_b;
      int         sz;
      r_en = ($urandom_range(0, 9) != 0);
      r_cl = ($urandom_range(0, 59) == 0);
      r_iv = ($urandom_range(0, 9) < 7);
      r_or = ($urandom_range(0, 9) < 5);
      r_a  = 8'($urandom);
      r_b  = 8'($urandom);
      drive(r_en, r_cl, r_iv, r_or, r_a, r_b);
      @(posedge clk);
      sz = q.size();
      if (r_en) begin
        if (r_cl) begin
          q.delete();
          mdrop = 0;
          mcs = 0;
        end else begin
          if (r_iv && sz == 4 && mdrop < 255) mdrop++;
          if (r_or && sz > 0) void'(q.pop_front());
          if (r_iv && sz < 4) begin
            q.push_back(9'(int'(r_a) + int'(r_b)));
            if (int'(r_a) + int'(r_b) > 255) mcs = 1;
          end
        end
      end
      #1;
      chk_state($sformatf("rand%0d", n), q.size(), q.size() != 0, q.size() != 4,
                (q.size() != 0) ? int'(q[0][7:0]) : 0,
                (q.size() != 0) ? int'(q[0][8]) : 0, mdrop, mcs);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
